// File: rtl/shader_dispatch.sv
// Triangle scheduler: FIFO-buffered triangles issued round-robin to idle shaders, colours returned round-robin.
// Latency: push->issue 1 cycle min, done->color_valid_out 2 cycles; stalls upstream via tri_ready_out when FIFO full.
// Optional SHADER_DISPATCH_STATS_EN adds issued/stall counters.

module shader_dispatch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
endmodule

module shader_dispatch #(
    parameter int NUM_SHADERS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int COORD_W     = 32,
    parameter int COLOR_W     = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             tri_valid_in,
    output logic                             tri_ready_out,
    input  logic [9*COORD_W-1:0]             tri_in,
    output logic [NUM_SHADERS-1:0]           shader_start_out,
    output logic [9*COORD_W-1:0]             shader_tri_out,
    input  logic [NUM_SHADERS-1:0]           shader_done_in,
    input  logic [NUM_SHADERS*COLOR_W-1:0]   shader_color_in,
    output logic                             color_valid_out,
    output logic [COLOR_W-1:0]               color_out,
    output logic [$clog2(NUM_SHADERS)-1:0]   color_id_out,
    output logic                             busy_out
`ifdef SHADER_DISPATCH_STATS_EN
    ,
    output logic [31:0]                      stat_issued_out,
    output logic [31:0]                      stat_stall_out
`endif
);
    localparam int TW = 9 * COORD_W;
    localparam int PW = $clog2(NUM_SHADERS);

    typedef enum logic [1:0] {U_IDLE, U_BUSY, U_DONE} unit_state_t;

    unit_state_t        ustate     [NUM_SHADERS];
    unit_state_t        ustate_nxt [NUM_SHADERS];
    logic [COLOR_W-1:0] result     [NUM_SHADERS];

    logic [PW-1:0]          issue_ptr, ret_ptr, issue_k, ret_k;
    logic                   issue_go, ret_go, idle_found;
    logic [NUM_SHADERS-1:0] idle_vec, done_vec;
    logic                   fifo_full, fifo_empty, push;
    logic [TW-1:0]          head_dat;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [NUM_SHADERS-1:0] vec,
                                            input logic [PW-1:0] ptr);
        logic [PW:0]   r;
        logic [PW-1:0] ix;
        int            idx;
        r = '0;
        for (int j = 0; j < NUM_SHADERS; j++) begin
            idx = int'(ptr) + j;
            if (idx >= NUM_SHADERS) idx = idx - NUM_SHADERS;
            ix = PW'(idx);
            if (!r[PW] && vec[ix]) r = {1'b1, ix};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
        return (k == PW'(NUM_SHADERS - 1)) ? '0 : k + 1'b1;
    endfunction

    shader_dispatch_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (push),
        .push_dat (tri_in),
        .pop      (issue_go),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tri_ready_out = !fifo_full;
    assign push          = tri_valid_in && !fifo_full;
    assign busy_out      = !fifo_empty || (idle_vec != {NUM_SHADERS{1'b1}});

    always_comb begin
        idle_vec = '0;
        done_vec = '0;
        for (int i = 0; i < NUM_SHADERS; i++) begin
            idle_vec[i] = (ustate[i] == U_IDLE);
            done_vec[i] = (ustate[i] == U_DONE);
        end
    end

    assign {idle_found, issue_k} = rr_pick(idle_vec, issue_ptr);
    assign {ret_go, ret_k}       = rr_pick(done_vec, ret_ptr);
    assign issue_go              = idle_found && !fifo_empty;

    // A unit leaving DONE goes to IDLE but was not in idle_vec this cycle, so it cannot also be issued.
    always_comb begin
        for (int i = 0; i < NUM_SHADERS; i++) begin
            ustate_nxt[i] = ustate[i];
            if (ustate[i] == U_BUSY && shader_done_in[i]) ustate_nxt[i] = U_DONE;
        end
        if (ret_go)   ustate_nxt[ret_k]   = U_IDLE;
        if (issue_go) ustate_nxt[issue_k] = U_BUSY;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_SHADERS; i++) begin
                ustate[i] <= U_IDLE;
                result[i] <= '0;
            end
            issue_ptr        <= '0;
            ret_ptr          <= '0;
            shader_start_out <= '0;
            shader_tri_out   <= '0;
            color_valid_out  <= 1'b0;
            color_out        <= '0;
            color_id_out     <= '0;
        end else begin
            for (int i = 0; i < NUM_SHADERS; i++) begin
                ustate[i] <= ustate_nxt[i];
                if (ustate[i] == U_BUSY && shader_done_in[i])
                    result[i] <= shader_color_in[i*COLOR_W +: COLOR_W];
            end
            shader_start_out <= '0;
            if (issue_go) begin
                shader_start_out[issue_k] <= 1'b1;
                shader_tri_out            <= head_dat;
                issue_ptr                 <= wrap_inc(issue_k);
            end
            color_valid_out <= ret_go;
            if (ret_go) begin
                color_out    <= result[ret_k];
                color_id_out <= ret_k;
                ret_ptr      <= wrap_inc(ret_k);
            end
        end
    end

`ifdef SHADER_DISPATCH_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_issued_out <= '0;
            stat_stall_out  <= '0;
        end else begin
            if (issue_go) stat_issued_out <= stat_issued_out + 32'd1;
            if (!fifo_empty && !idle_found) stat_stall_out <= stat_stall_out + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shader_dispatch.sv
// Self-checking bench for shader_dispatch: directed scenarios plus random traffic against a queue-based model.
module tb_shader_dispatch;
    localparam int N    = 4;
    localparam int D    = 8;
    localparam int CW   = 32;
    localparam int COLW = 8;
    localparam int TW   = 9 * CW;
    localparam int PW   = 2;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              tri_valid_in = 1'b0;
    logic              tri_ready_out;
    logic [TW-1:0]     tri_in = '0;
    logic [N-1:0]      shader_start_out;
    logic [TW-1:0]     shader_tri_out;
    logic [N-1:0]      shader_done_in = '0;
    logic [N*COLW-1:0] shader_color_in = '0;
    logic              color_valid_out;
    logic [COLW-1:0]   color_out;
    logic [PW-1:0]     color_id_out;
    logic              busy_out;
`ifdef SHADER_DISPATCH_STATS_EN
    logic [31:0]       stat_issued_out;
    logic [31:0]       stat_stall_out;
`endif

    always #5 clk_in = ~clk_in;

    shader_dispatch #(.NUM_SHADERS(N), .FIFO_DEPTH(D), .COORD_W(CW), .COLOR_W(COLW)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .tri_valid_in     (tri_valid_in),
        .tri_ready_out    (tri_ready_out),
        .tri_in           (tri_in),
        .shader_start_out (shader_start_out),
        .shader_tri_out   (shader_tri_out),
        .shader_done_in   (shader_done_in),
        .shader_color_in  (shader_color_in),
        .color_valid_out  (color_valid_out),
        .color_out        (color_out),
        .color_id_out     (color_id_out),
        .busy_out         (busy_out)
`ifdef SHADER_DISPATCH_STATS_EN
        ,
        .stat_issued_out  (stat_issued_out),
        .stat_stall_out   (stat_stall_out)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: triangle queue plus per-unit status (0 idle, 1 busy, 2 done).
    logic [TW-1:0]   fq [$];
    int              ust [N];
    logic [COLW-1:0] res [N];
    int              iptr, rptr;
    logic [N-1:0]    e_start;
    logic [TW-1:0]   e_tri;
    logic            e_cv;
    logic [COLW-1:0] e_col;
    logic [PW-1:0]   e_id;
    logic [31:0]     e_iss, e_stall;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_from(input int ptr, input int want);
        for (int j = 0; j < N; j++)
            if (ust[(ptr + j) % N] == want) return (ptr + j) % N;
        return -1;
    endfunction

    task automatic model_step();
        int  ki, kf;
        bit  can_push;
        if (rst_in) begin
            fq.delete();
            for (int i = 0; i < N; i++) begin ust[i] = 0; res[i] = '0; end
            iptr = 0; rptr = 0;
            e_start = '0; e_tri = '0; e_cv = 1'b0; e_col = '0; e_id = '0;
            e_iss = '0; e_stall = '0;
            return;
        end
        can_push = (fq.size() < D);
        ki = first_from(iptr, 0);
        kf = first_from(rptr, 2);
        if (fq.size() > 0 && ki < 0) e_stall++;
        for (int i = 0; i < N; i++)
            if (ust[i] == 1 && shader_done_in[i]) begin
                ust[i] = 2;
                res[i] = shader_color_in[i*COLW +: COLW];
            end
        e_cv = 1'b0;
        if (kf >= 0) begin
            e_cv  = 1'b1;
            e_col = res[kf];
            e_id  = PW'(kf);
            ust[kf] = 0;
            rptr = (kf + 1) % N;
        end
        e_start = '0;
        if (fq.size() > 0 && ki >= 0) begin
            e_start[ki] = 1'b1;
            e_tri = fq.pop_front();
            ust[ki] = 1;
            iptr = (ki + 1) % N;
            e_iss++;
        end
        if (tri_valid_in && can_push) fq.push_back(tri_in);
    endtask

    task automatic check_all();
        bit bz;
        bz = (fq.size() > 0);
        for (int i = 0; i < N; i++) if (ust[i] != 0) bz = 1'b1;
        chk("ready", TW'(tri_ready_out), TW'(fq.size() < D));
        chk("busy", TW'(busy_out), TW'(bz));
        chk("start", TW'(shader_start_out), TW'(e_start));
        chk("tri", shader_tri_out, e_tri);
        chk("cvalid", TW'(color_valid_out), TW'(e_cv));
        chk("color", TW'(color_out), TW'(e_col));
        chk("color_id", TW'(color_id_out), TW'(e_id));
`ifdef SHADER_DISPATCH_STATS_EN
        chk("stat_issued", TW'(stat_issued_out), TW'(e_iss));
        chk("stat_stall", TW'(stat_stall_out), TW'(e_stall));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    function automatic logic [TW-1:0] rand_tri();
        logic [TW-1:0] t;
        for (int w = 0; w < 9; w++) t[w*CW +: CW] = $urandom;
        return t;
    endfunction

    logic [TW-1:0] t1;

    initial begin
        // Reset state
        rst_in = 1'b1;
        tick();
        tick();
        chk("rst_ready", TW'(tri_ready_out), TW'(1));
        chk("rst_busy", TW'(busy_out), TW'(0));
        chk("rst_cvalid", TW'(color_valid_out), TW'(0));
        rst_in = 1'b0;

        // Single triangle round trip
        t1 = '0;
        t1[0 +: CW] = 32'd7; t1[CW +: CW] = 32'd21; t1[2*CW +: CW] = 32'd30;
        tri_in = t1; tri_valid_in = 1'b1;
        tick();
        tri_valid_in = 1'b0;
        chk("t1_no_bypass", TW'(shader_start_out), TW'(0));
        tick();
        chk("t1_start", TW'(shader_start_out), TW'(4'b0001));
        chk("t1_tri", shader_tri_out, t1);
        shader_done_in = 4'b0001; shader_color_in = 32'h0000_005A;
        tick();
        shader_done_in = '0;
        chk("t1_not_yet", TW'(color_valid_out), TW'(0));
        tick();
        chk("t1_cvalid", TW'(color_valid_out), TW'(1));
        chk("t1_color", TW'(color_out), TW'(8'h5A));
        chk("t1_id", TW'(color_id_out), TW'(0));
        tick();
        chk("t1_pulse", TW'(color_valid_out), TW'(0));

        // Six back-to-back pushes, shaders never finish
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tri_in = rand_tri(); tri_valid_in = 1'b1;
            tick();
        end
        tri_valid_in = 1'b0;
        tick(); tick();
        chk("t2_busy", TW'(busy_out), TW'(1));
        chk("t2_queued", TW'(fq.size()), TW'(2));

        // Fill until the FIFO refuses, then hold an offered triangle
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tri_in = rand_tri(); tri_valid_in = 1'b1;
            tick();
        end
        for (int g = 0; g < 12 && tri_ready_out; g++) begin
            tri_in = rand_tri();
            tick();
        end
        chk("t3_full", TW'(tri_ready_out), TW'(0));
        tri_in = rand_tri();
        tick(); tick();
        chk("t3_held", TW'(tri_ready_out), TW'(0));
        tri_valid_in = 1'b0;

        // Simultaneous done on units 3 and 1
        shader_done_in = 4'b1010;
        shader_color_in = {8'h33, 8'h00, 8'h11, 8'h00};
        tick();
        shader_done_in = '0;
        tick();
        chk("t4_cv_a", TW'(color_valid_out), TW'(1));
        chk("t4_id_a", TW'(color_id_out), TW'(1));
        chk("t4_col_a", TW'(color_out), TW'(8'h11));
        tick();
        chk("t4_cv_b", TW'(color_valid_out), TW'(1));
        chk("t4_id_b", TW'(color_id_out), TW'(3));
        chk("t4_col_b", TW'(color_out), TW'(8'h33));

        // Done on an idle unit is ignored
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        shader_done_in = 4'b0100; shader_color_in = {8'h00, 8'h77, 8'h00, 8'h00};
        tick();
        shader_done_in = '0;
        tick(); tick();
        chk("t5_cvalid", TW'(color_valid_out), TW'(0));
        chk("t5_busy", TW'(busy_out), TW'(0));

        // Reset while busy with work queued
        for (int i = 0; i < 6; i++) begin
            tri_in = rand_tri(); tri_valid_in = 1'b1;
            tick();
        end
        tri_valid_in = 1'b0;
        tick(); tick(); tick();
        chk("t6_busy_before", TW'(busy_out), TW'(1));
`ifdef SHADER_DISPATCH_STATS_EN
        chk("t6_issued", TW'(stat_issued_out), TW'(4));
        chk("t6_stall", TW'(stat_stall_out), TW'(4));
`endif
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        chk("t6_busy", TW'(busy_out), TW'(0));
        chk("t6_ready", TW'(tri_ready_out), TW'(1));
`ifdef SHADER_DISPATCH_STATS_EN
        chk("t6_issued_clr", TW'(stat_issued_out), TW'(0));
        chk("t6_stall_clr", TW'(stat_stall_out), TW'(0));
`endif

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            rst_in          = ($urandom_range(0, 199) == 0);
            tri_valid_in    = ($urandom_range(0, 9) < 6);
            tri_in          = rand_tri();
            for (int i = 0; i < N; i++) shader_done_in[i] = ($urandom_range(0, 9) < 3);
            shader_color_in = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
